otter_iobus_timer: RTL

- Memory-mapped timer/compare peripheral. It is the responder on the OTTER MCU IOBUS: it decodes IOBUS_ADDR/IOBUS_OUT/IOBUS_WR and returns read data on IOBUS_IN.
- Its level interrupt INTR is wired to the MCU's CPU_INTR.
- Provides a prescaled 32-bit up-counter, a compare match, optional auto-reload, and a write-1-to-clear pending flag.

---
 rtl/otter_io_pkg.sv | 23 ++
 rtl/otter_timer_prescaler.sv | 32 +++
 rtl/otter_iobus_timer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/otter_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | otter_io_pkg: IOBUS address map and timer register layout constants        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package otter_io_pkg;

  localparam logic [31:0] IOBUS_BASE       = 32'h1100_0000;
  localparam logic [31:0] IOBUS_TIMER_BASE = 32'h1100_0100;
  localparam int          IOBUS_TIMER_SPAN = 16;

  localparam logic [1:0] TMR_CTRL_OFS  = 2'd0;
  localparam logic [1:0] TMR_COUNT_OFS = 2'd1;
  localparam logic [1:0] TMR_CMP_OFS   = 2'd2;
  localparam logic [1:0] TMR_STAT_OFS  = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_AR      = 2;
  localparam int CTRL_PSC_LSB = 8;

endpackage
`default_nettype wire

// File: rtl/otter_timer_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | otter_timer_prescaler: divides the clock by PRESCALE+1 while enabled       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module otter_timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  CLR,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] psc;

  assign tick = EN && (psc == PRESCALE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      psc <= '0;
    end else if (CLR || tick) begin
      psc <= '0;
    end else if (EN) begin
      psc <= psc + PRESCALE_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/otter_iobus_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | otter_iobus_timer: IOBUS timer with compare match, auto-reload, W1C flag   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module otter_iobus_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = IOBUS_TIMER_BASE,
  parameter int          PRESCALE_W = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  logic                  hit;
  logic [1:0]            ofs;
  logic                  wr_ctrl;
  logic                  wr_count;
  logic                  wr_cmp;
  logic                  wr_stat;
  logic                  en;
  logic                  ie;
  logic                  ar;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  pending;
  logic                  tick;
  logic                  match;
  logic [31:0]           ctrl_rd;
  logic                  unused_addr_bits;

  assign hit              = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign ofs              = IOBUS_ADDR[3:2];
  assign unused_addr_bits = ^IOBUS_ADDR[1:0];

  assign wr_ctrl  = IOBUS_WR && hit && (ofs == TMR_CTRL_OFS);
  assign wr_count = IOBUS_WR && hit && (ofs == TMR_COUNT_OFS);
  assign wr_cmp   = IOBUS_WR && hit && (ofs == TMR_CMP_OFS);
  assign wr_stat  = IOBUS_WR && hit && (ofs == TMR_STAT_OFS);

  otter_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .EN       (en),
    .CLR      (wr_ctrl),
    .PRESCALE (prescale),
    .tick     (tick)
  );

  // Match is judged against the registers as they stand before this edge
  assign match = tick && (count == compare);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      en       <= 1'b0;
      ie       <= 1'b0;
      ar       <= 1'b0;
      prescale <= '0;
    end else if (wr_ctrl) begin
      en       <= IOBUS_OUT[CTRL_EN];
      ie       <= IOBUS_OUT[CTRL_IE];
      ar       <= IOBUS_OUT[CTRL_AR];
      prescale <= IOBUS_OUT[CTRL_PSC_LSB +: PRESCALE_W];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (wr_count) begin
      count <= IOBUS_OUT;
    end else if (tick) begin
      count <= (match && ar) ? 32'd0 : count + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      compare <= 32'hFFFF_FFFF;
    end else if (wr_cmp) begin
      compare <= IOBUS_OUT;
    end
  end

  // A new match outranks a simultaneous write-1-to-clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending <= 1'b0;
    end else if (match) begin
      pending <= 1'b1;
    end else if (wr_stat && IOBUS_OUT[0]) begin
      pending <= 1'b0;
    end
  end

  always_comb begin
    ctrl_rd                                 = '0;
    ctrl_rd[CTRL_EN]                        = en;
    ctrl_rd[CTRL_IE]                        = ie;
    ctrl_rd[CTRL_AR]                        = ar;
    ctrl_rd[CTRL_PSC_LSB +: PRESCALE_W]     = prescale;
  end

  always_comb begin
    IOBUS_IN = 32'h0;
    if (hit) begin
      case (ofs)
        TMR_CTRL_OFS:  IOBUS_IN = ctrl_rd;
        TMR_COUNT_OFS: IOBUS_IN = count;
        TMR_CMP_OFS:   IOBUS_IN = compare;
        default:       IOBUS_IN = {31'h0, pending};
      endcase
    end
  end

  assign INTR = pending && ie;

endmodule
`default_nettype wire
